// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types.
// Block/word widths and the pmem responder state names.
package lc3b_types;

  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 16;

  typedef logic [BLOCK_W-1:0] lc3b_block;
  typedef logic [WORD_W-1:0]  lc3b_word;

  typedef enum logic [1:0] {
    PMEM_IDLE = 2'd0,
    PMEM_WAIT = 2'd1,
    PMEM_RESP = 2'd2
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_array.sv
// Backing store of 128-bit lines.
// Synchronous write, registered read, contents never reset.
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int DEPTH_LOG = 5
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [DEPTH_LOG-1:0] waddr_i,
  input  lc3b_block            wdata_i,
  input  logic                 re_i,
  input  logic [DEPTH_LOG-1:0] raddr_i,
  output lc3b_block            rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  lc3b_block mem_q [DEPTH];
  lc3b_block rdata_q;

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_block_responder.sv
// Physical-memory end of the L2 pmem_* bus.
// One block op at a time, answered after DELAY wait cycles.
module pmem_block_responder
  import lc3b_types::*;
#(
  parameter int DEPTH_LOG = 5,
  parameter int DELAY     = 4,
  parameter int CNT_W     = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      pmem_read,
  input  logic      pmem_write,
  input  lc3b_word  pmem_address,
  input  lc3b_block pmem_wdata,
  output logic      pmem_resp,
  output lc3b_block pmem_rdata
);

  localparam int LOAD = (DELAY == 0) ? 0 : DELAY - 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD);

  pmem_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic [DEPTH_LOG-1:0] idx_q, idx_d;
  lc3b_block            wdata_q, wdata_d;
  lc3b_block            rdata_q;
  lc3b_block            arr_rdata;

  logic req;
  logic enter_resp;
  logic arr_we;
  logic arr_re;
  logic rd_resp;
  logic unused_addr;

  assign req = pmem_read | pmem_write;
  assign unused_addr = ^{pmem_address[15:DEPTH_LOG+4],
                         pmem_address[3:0]};

  // next-state, counter and request latches
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    unique case (state_q)
      PMEM_IDLE: begin
        if (req) begin
          wr_d    = pmem_write;
          idx_d   = pmem_address[DEPTH_LOG+3:4];
          wdata_d = pmem_wdata;
          if (DELAY == 0) begin
            state_d = PMEM_RESP;
          end else begin
            state_d = PMEM_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      PMEM_WAIT: begin
        if (!req) begin
          state_d = PMEM_IDLE;
        end else if (cnt_q == '0) begin
          state_d = PMEM_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PMEM_RESP: begin
        state_d = PMEM_IDLE;
      end
      default: begin
        state_d = PMEM_IDLE;
      end
    endcase
  end

  // commit/fetch on the edge entering RESP; gated so an
  // asserted reset can never let a write slip through
  assign enter_resp = reset && (state_q != PMEM_RESP)
                      && (state_d == PMEM_RESP);
  assign arr_we = enter_resp && wr_d;
  assign arr_re = enter_resp && !wr_d;

  // state, counter and latched request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PMEM_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  pmem_line_array #(
    .DEPTH_LOG(DEPTH_LOG)
  ) u_array (
    .clk    (clk),
    .we_i   (arr_we),
    .waddr_i(idx_d),
    .wdata_i(wdata_d),
    .re_i   (arr_re),
    .raddr_i(idx_d),
    .rdata_o(arr_rdata)
  );

  assign rd_resp = (state_q == PMEM_RESP) && !wr_q;

  // hold the last read block outside RESP; array itself has no reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (rd_resp) begin
      rdata_q <= arr_rdata;
    end
  end

  assign pmem_resp  = (state_q == PMEM_RESP);
  assign pmem_rdata = rd_resp ? arr_rdata : rdata_q;

endmodule

// File: tb/tb_pmem_block_responder.sv
// Directed bench for pmem_block_responder.
// DELAY=4 instance for main checks, DELAY=0 for back-to-back.
module tb_pmem_block_responder;
  import lc3b_types::*;

  localparam int DLY = 4;

  logic clk = 1'b0;
  logic reset;

  logic      rd0, we0, resp0;
  lc3b_word  addr0;
  lc3b_block wd0, rdata0;

  logic      rd1, we1, resp1;
  lc3b_word  addr1;
  lc3b_block wd1, rdata1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pmem_block_responder #(
    .DEPTH_LOG(5), .DELAY(DLY), .CNT_W(4)
  ) dut0 (
    .clk         (clk),
    .reset       (reset),
    .pmem_read   (rd0),
    .pmem_write  (we0),
    .pmem_address(addr0),
    .pmem_wdata  (wd0),
    .pmem_resp   (resp0),
    .pmem_rdata  (rdata0)
  );

  pmem_block_responder #(
    .DEPTH_LOG(5), .DELAY(0), .CNT_W(4)
  ) dut1 (
    .clk         (clk),
    .reset       (reset),
    .pmem_read   (rd1),
    .pmem_write  (we1),
    .pmem_address(addr1),
    .pmem_wdata  (wd1),
    .pmem_resp   (resp1),
    .pmem_rdata  (rdata1)
  );

  typedef struct {
    bit        wr;
    lc3b_word  addr;
    lc3b_block data;
    string     nm;
  } vec_t;

  vec_t tbl [8];

  localparam lc3b_block D1 =
    128'h0123456789ABCDEF0123456789ABCDEF;
  localparam lc3b_block DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam lc3b_block DB = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
  localparam lc3b_block DC = 128'hCCCC_CCCC_0000_1234_CCCC_CCCC_5678_0000;
  localparam lc3b_block DE = 128'hEEEE_0000_EEEE_1111_EEEE_2222_EEEE_3333;
  localparam lc3b_block DF = 128'hFFFF_DEAD_FFFF_BEEF_FFFF_DEAD_FFFF_BEEF;
  localparam lc3b_block DG = 128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0;
  localparam lc3b_block DH = 128'h9999_8888_7777_6666_5555_4444_3333_2222;

  task automatic chk(input string nm, input lc3b_block act,
                     input lc3b_block exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc0();
    @(posedge clk);
    #1;
  endtask

  // full handshake on dut0; latency counted in edges from acceptance
  task automatic txn(input bit wr, input lc3b_word a,
                     input lc3b_block d, input string nm);
    int lat;
    lat = 0;
    @(negedge clk);
    rd0 = !wr; we0 = wr; addr0 = a; wd0 = d;
    do begin
      cyc0();
      lat++;
    end while (!resp0 && lat < 20);
    chk({nm, "_lat"}, 128'(lat), 128'(DLY + 1));
    if (!wr) chk({nm, "_rdata"}, rdata0, d);
    @(negedge clk);
    rd0 = 1'b0; we0 = 1'b0;
    cyc0();
    chk({nm, "_width"}, 128'(resp0), 128'd0);
  endtask

  // request held for n edges then dropped; resp must never appear
  task automatic abort_seq(input bit wr, input lc3b_word a,
                           input lc3b_block d, input string nm);
    @(negedge clk);
    rd0 = !wr; we0 = wr; addr0 = a; wd0 = d;
    for (int i = 0; i < 3; i++) begin
      cyc0();
      chk({nm, "_hold"}, 128'(resp0), 128'd0);
    end
    @(negedge clk);
    rd0 = 1'b0; we0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc0();
      chk({nm, "_after"}, 128'(resp0), 128'd0);
    end
  endtask

  initial begin
    int lat;
    bit prev;
    reset = 1'b0;
    rd0 = 0; we0 = 0; addr0 = '0; wd0 = '0;
    rd1 = 0; we1 = 0; addr1 = '0; wd1 = '0;

    tbl[0] = '{1'b1, 16'h0040, D1, "wr40"};
    tbl[1] = '{1'b0, 16'h0040, D1, "rd40"};
    tbl[2] = '{1'b1, 16'h0010, DA, "wr10"};
    tbl[3] = '{1'b1, 16'h0210, DB, "wr210"};
    tbl[4] = '{1'b0, 16'h0010, DB, "alias"};
    tbl[5] = '{1'b0, 16'h0013, DB, "lowbits"};
    tbl[6] = '{1'b1, 16'h0080, DC, "wr80"};
    tbl[7] = '{1'b1, 16'h00C0, DE, "wrC0"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc0();
      chk("rst_resp", 128'(resp0), 128'd0);
      chk("rst_rdata", rdata0, 128'd0);
    end

    foreach (tbl[i]) begin
      txn(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].nm);
    end

    abort_seq(1'b0, 16'h0080, '0, "abort_rd");
    abort_seq(1'b1, 16'h0080, DF, "abort_wr");
    txn(1'b0, 16'h0080, DC, "rd80_kept");

    // reset pulse in the middle of a write's WAIT
    @(negedge clk);
    we0 = 1'b1; addr0 = 16'h00C0; wd0 = DF;
    repeat (2) cyc0();
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_mid_resp", 128'(resp0), 128'd0);
    chk("rst_mid_state", 128'(dut0.state_q), 128'(PMEM_IDLE));
    chk("rst_mid_rdata", rdata0, 128'd0);
    @(negedge clk);
    we0 = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc0();
      chk("rst_mid_quiet", 128'(resp0), 128'd0);
    end
    txn(1'b0, 16'h00C0, DE, "rdC0_kept");

    // inputs changing during WAIT must not affect the op
    @(negedge clk);
    we0 = 1'b1; addr0 = 16'h0100; wd0 = DG;
    cyc0();
    @(negedge clk);
    addr0 = 16'h0140; wd0 = DH;
    lat = 1;
    do begin
      cyc0();
      lat++;
    end while (!resp0 && lat < 20);
    chk("latch_lat", 128'(lat), 128'(DLY + 1));
    @(negedge clk);
    we0 = 1'b0;
    cyc0();
    txn(1'b0, 16'h0100, DG, "latch_rd");

    // DELAY=0: one write, then a read held across three answers
    @(negedge clk);
    we1 = 1'b1; addr1 = 16'h0040; wd1 = D1;
    cyc0();
    chk("d0_wr_resp", 128'(resp1), 128'd1);
    @(negedge clk);
    we1 = 1'b0;
    cyc0();
    chk("d0_wr_width", 128'(resp1), 128'd0);
    @(negedge clk);
    rd1 = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc0();
      chk("d0_b2b_resp", 128'(resp1), 128'((i % 2) == 0));
      if (resp1) chk("d0_b2b_rdata", rdata1, D1);
      chk("d0_no_consec", 128'(prev && resp1), 128'd0);
      prev = resp1;
      if (i == 4) begin
        @(negedge clk);
        rd1 = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
